// File: rtl/noc_inject_arbiter_pkg.sv
// rtl/noc_inject_arbiter_pkg.sv - shared widths and FSM encoding for the injection arbiter
package noc_inject_arbiter_pkg;

    localparam int NOC_DATA_WIDTH = 32;
    localparam int PKT_COUNT_W    = 16;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/noc_rr_pick.sv
// rtl/noc_rr_pick.sv - round-robin pick of the first eligible source at or after a pointer
// Ports:
//   i_eligible  per-source eligibility vector
//   i_rr_ptr    index where the search starts
//   o_valid     at least one source is eligible
//   o_index     winning source index (0 when o_valid=0)
module noc_rr_pick
    import noc_inject_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_eligible,
    input  logic [IDX_W-1:0]   i_rr_ptr,
    output logic               o_valid,
    output logic [IDX_W-1:0]   o_index
);

    // Walk from the farthest offset down to offset 0 so the candidate
    // nearest the pointer is written last and therefore wins.
    always_comb begin
        logic [IDX_W:0]   w_sum;
        logic [IDX_W-1:0] w_cand;
        o_valid = 1'b0;
        o_index = '0;
        w_sum   = '0;
        w_cand  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, i_rr_ptr} + (IDX_W + 1)'(k);
            if (w_sum >= (IDX_W + 1)'(NUM_REQ)) begin
                w_sum = w_sum - (IDX_W + 1)'(NUM_REQ);
            end
            w_cand = w_sum[IDX_W-1:0];
            if (i_eligible[w_cand]) begin
                o_valid = 1'b1;
                o_index = w_cand;
            end
        end
    end

endmodule

// File: rtl/noc_inject_arbiter.sv
// rtl/noc_inject_arbiter.sv - packet-atomic round-robin arbiter for a router injection port
// Ports:
//   noc_clk, noc_rst_n               clock, asynchronous active-low reset
//   req_valid/req_ready              per-source flit handshake
//   req_flit                         packed flits, source i at [i*DATA_W +: DATA_W]
//   req_is_header/req_is_tail        per-source packet markers
//   out_valid/out_ready              injection-port handshake
//   out_flit/out_is_header/out_is_tail/out_src  registered output flit and owner
//   pkt_count                        wrapping count of tails sent
//   err_proto                        sticky protocol-error flag
module noc_inject_arbiter
    import noc_inject_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = NOC_DATA_WIDTH
) (
    input  logic                         noc_clk,
    input  logic                         noc_rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]    req_flit,
    input  logic [NUM_REQ-1:0]           req_is_header,
    input  logic [NUM_REQ-1:0]           req_is_tail,
    output logic                         out_valid,
    output logic                         out_is_header,
    output logic                         out_is_tail,
    output logic [DATA_W-1:0]            out_flit,
    input  logic                         out_ready,
    output logic [$clog2(NUM_REQ)-1:0]   out_src,
    output logic [PKT_COUNT_W-1:0]       pkt_count,
    output logic                         err_proto
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e            r_state;
    arb_state_e            w_state_nxt;
    logic [IDX_W-1:0]      r_owner;
    logic [IDX_W-1:0]      w_owner_nxt;
    logic [IDX_W-1:0]      r_rr_ptr;
    logic [IDX_W-1:0]      w_rr_ptr_nxt;

    logic [NUM_REQ-1:0]    w_eligible;
    logic                  w_pick_valid;
    logic [IDX_W-1:0]      w_pick_idx;
    logic                  w_grant_valid;
    logic [IDX_W-1:0]      w_grant_idx;
    logic [IDX_W-1:0]      w_grant_inc;
    logic [DATA_W-1:0]     w_grant_flit;
    logic                  w_out_free;
    logic                  w_accept;
    logic                  w_err_set;

    logic                  r_out_valid;
    logic                  r_out_is_header;
    logic                  r_out_is_tail;
    logic [DATA_W-1:0]     r_out_flit;
    logic [IDX_W-1:0]      r_out_src;
    logic [PKT_COUNT_W-1:0] r_pkt_count;
    logic                  r_err_proto;

    // Only headers can open a packet, so only they compete in IDLE.
    assign w_eligible = req_valid & req_is_header;

    noc_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .i_eligible (w_eligible),
        .i_rr_ptr   (r_rr_ptr),
        .o_valid    (w_pick_valid),
        .o_index    (w_pick_idx)
    );

    // The output register can take a flit when empty or draining this cycle.
    assign w_out_free = !r_out_valid || out_ready;

    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = r_owner;
        if (r_state == ST_IDLE) begin
            w_grant_valid = w_pick_valid;
            w_grant_idx   = w_pick_idx;
        end else begin
            w_grant_valid = 1'b1;
        end
    end

    assign w_grant_inc  = (w_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + IDX_W'(1);
    assign w_grant_flit = req_flit[int'(w_grant_idx) * DATA_W +: DATA_W];
    assign w_accept     = noc_rst_n && w_grant_valid && w_out_free && req_valid[w_grant_idx];

    // Ready is gated by reset so no source sees a handshake while held in reset.
    always_comb begin
        req_ready = '0;
        if (noc_rst_n && w_grant_valid && w_out_free) begin
            req_ready[w_grant_idx] = 1'b1;
        end
    end

    always_comb begin
        w_err_set = 1'b0;
        if (r_state == ST_IDLE) begin
            w_err_set = |(req_valid & ~req_is_header);
        end else begin
            w_err_set = req_valid[r_owner] && req_is_header[r_owner];
        end
    end

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            r_state  <= ST_IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_rr_ptr_nxt = r_rr_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (req_is_tail[w_grant_idx]) begin
                        // Single-flit packet: never lock, just advance fairness.
                        w_rr_ptr_nxt = w_grant_inc;
                    end else begin
                        w_state_nxt = ST_LOCKED;
                        w_owner_nxt = w_grant_idx;
                    end
                end
            end
            ST_LOCKED: begin
                if (w_accept && req_is_tail[w_grant_idx]) begin
                    w_state_nxt  = ST_IDLE;
                    w_rr_ptr_nxt = w_grant_inc;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            r_out_valid     <= 1'b0;
            r_out_is_header <= 1'b0;
            r_out_is_tail   <= 1'b0;
            r_out_flit      <= '0;
            r_out_src       <= '0;
            r_pkt_count     <= '0;
            r_err_proto     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_out_valid     <= 1'b1;
                r_out_is_header <= req_is_header[w_grant_idx];
                r_out_is_tail   <= req_is_tail[w_grant_idx];
                r_out_flit      <= w_grant_flit;
                r_out_src       <= w_grant_idx;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (r_out_valid && out_ready && r_out_is_tail) begin
                r_pkt_count <= r_pkt_count + PKT_COUNT_W'(1);
            end
            if (w_err_set) begin
                r_err_proto <= 1'b1;
            end
        end
    end

    assign out_valid     = r_out_valid;
    assign out_is_header = r_out_is_header;
    assign out_is_tail   = r_out_is_tail;
    assign out_flit      = r_out_flit;
    assign out_src       = r_out_src;
    assign pkt_count     = r_pkt_count;
    assign err_proto     = r_err_proto;

endmodule

// File: doc/noc_inject_arbiter.md
NOC_INJECT_ARBITER -- requirements
Module: noc_inject_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4; number of local flit sources sharing one router injection port (2..8).
REQ-002 Parameter DATA_W, default `Noc_Data_Width; flit width.
REQ-003 noc_clk  in  1  clock; all state on rising edge.
REQ-004 noc_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  NUM_REQ  per-source flit valid.
REQ-006 req_ready  out  NUM_REQ  per-source flit accept.
REQ-007 req_flit  in  NUM_REQ*DATA_W  packed flits, source i at bits [i*DATA_W +: DATA_W].
REQ-008 req_is_header, req_is_tail  in  NUM_REQ each  per-source flit markers.
REQ-009 out_valid, out_is_header, out_is_tail  out  1 each  injection-port flit valid and markers.
REQ-010 out_flit  out  DATA_W  injection-port flit.
REQ-011 out_ready  in  1  router accepts flit.
REQ-012 out_src  out  $clog2(NUM_REQ)  index of source owning out_flit.
REQ-013 pkt_count  out  16  packets (tails) sent on output port, wraps.
REQ-014 err_proto  out  1  sticky protocol-error flag.

Function
REQ-015 Transfer on any port SHALL occur when valid and ready are both 1 on a rising edge.
REQ-016 FSM SHALL have states IDLE (no owner) and LOCKED (owner = grant index).
REQ-017 In IDLE, eligible sources SHALL be those with req_valid=1 and req_is_header=1.
REQ-018 In IDLE, winner SHALL be the first eligible source at or after rr_ptr, modulo NUM_REQ.
REQ-019 Only the winner (IDLE) or owner (LOCKED) SHALL see req_ready=1, when (!out_valid || out_ready); all others SHALL see 0.
REQ-020 Accepted flit, markers and source index SHALL load the output register; out_valid SHALL assert next cycle (latency 1).
REQ-021 Output register SHALL hold unchanged while out_valid=1 and out_ready=0.
REQ-022 Header accepted without tail SHALL move IDLE->LOCKED with owner=winner.
REQ-023 Tail accepted from owner SHALL move LOCKED->IDLE and set rr_ptr=(owner+1) mod NUM_REQ.
REQ-024 Single-flit packet (header and tail both 1) SHALL stay in IDLE and update rr_ptr=(winner+1) mod NUM_REQ.
REQ-025 Back-to-back throughput SHALL be 1 flit/cycle while out_ready=1, including an IDLE grant in the cycle after a tail.
REQ-026 pkt_count SHALL increment by 1 on each output transfer with out_is_tail=1, wrapping 0xFFFF->0.
REQ-027 err_proto SHALL set when, in IDLE, any req_valid=1 with req_is_header=0.
REQ-028 err_proto SHALL also set when the owner in LOCKED presents req_valid=1 with req_is_header=1.
REQ-029 err_proto SHALL clear only on reset; offending flits SHALL NOT be accepted in IDLE.
REQ-030 Non-owner headers in LOCKED SHALL wait (ready=0), without error.

Reset
REQ-031 Reset SHALL give state=IDLE, rr_ptr=0, out_valid=0, out_flit=0, out_is_header=0, out_is_tail=0, out_src=0, pkt_count=0, err_proto=0.
REQ-032 Reset mid-packet SHALL drop the partial packet, with no flush flit emitted.
REQ-033 req_ready SHALL be 0 during reset.

Structure
REQ-034 Shared package/parameters SHALL hold DATA_W default, FSM state encodings (IDLE=0, LOCKED=1) and pkt_count width.
REQ-035 Round-robin winner selection SHALL be one sub-module, noc_rr_pick (inputs: eligible vector, rr_ptr; outputs: valid, index).

Verification
REQ-036 Src0 sends 3-flit packet, src1 header held from cycle 0 -> output src0 H,D,T on cycles 1-3, then src1 header on cycle 4, pkt_count=1 after src0 tail.
REQ-037 All 4 sources send single-flit packets continuously, out_ready=1 -> out_src sequence 0,1,2,3,0, one flit/cycle, pkt_count=5 after 5 cycles of output.
REQ-038 out_ready=0 for 3 cycles mid-packet -> out_flit stable, owner req_ready=0, no flit lost or duplicated.
REQ-039 Src2 presents data flit (is_header=0) in IDLE -> err_proto=1 next cycle, req_ready[2]=0, out_valid stays 0.
REQ-040 Reset asserted during LOCKED after header -> all outputs at REQ-031 values; a new src1 packet after release goes out from IDLE.
REQ-041 65536 single-flit packets -> pkt_count wraps to 0.
